updown_sweep_ctrl: RTL and testbench
====================================

UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 SHALL have parameter W, default 8: counter/limit width.
REQ-002 SHALL have parameter SW, default 4: sweep-count width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low (0 = reset, sampled on clk rising edge).
REQ-005 start  in  1  request a sweep run; honoured only in IDLE.
REQ-006 abort  in  1  terminate run; returns to IDLE next edge.
REQ-007 lo  in  W  lower sweep limit, captured on accepted start.
REQ-008 hi  in  W  upper sweep limit, captured on accepted start.
REQ-009 sweeps  in  SW  full up+down sweeps to run; 0 = continuous until abort.
REQ-010 count  out  W  current counter value.
REQ-011 up_down  out  1  direction: 1 = up, 0 = down.
REQ-012 busy  out  1  high in UP, DOWN and DONE states.
REQ-013 done  out  1  one-cycle pulse at normal completion.
REQ-014 err  out  1  one-cycle pulse on rejected start (lo >= hi).

Function
REQ-015 SHALL implement FSM states IDLE, UP, DOWN and DONE; all outputs registered or Moore-decoded, no input-to-output combinational path.
REQ-016 IDLE, start=1, abort=0, lo<hi: SHALL capture lo/hi/sweeps, load count<=lo, clear sweep counter, go UP.
REQ-017 IDLE, start=1, lo>=hi: SHALL assert err for exactly the next cycle, remain IDLE, leave count unchanged.
REQ-018 UP, count!=hi: SHALL increment count by 1 per cycle.
REQ-019 UP, count==hi: SHALL load count<=hi-1 and go DOWN; hi is visible exactly one cycle per sweep.
REQ-020 DOWN, count!=lo: SHALL decrement count by 1 per cycle.
REQ-021 DOWN, count==lo: SHALL increment the sweep counter; if sweeps!=0 and new value==captured sweeps, go DONE with count held at lo; otherwise load count<=lo+1 and go UP.
REQ-022 Steady-state period SHALL be 2*(hi-lo) cycles, lo visible one cycle per period.
REQ-023 DONE: SHALL assert done for exactly one cycle, hold count, return to IDLE.
REQ-024 up_down SHALL be 1 in IDLE/UP/DONE and 0 in DOWN.
REQ-025 abort=1 in UP/DOWN/DONE SHALL force IDLE next edge, hold count, no done pulse.
REQ-026 start and abort both high in IDLE: abort SHALL win; start ignored, no err.
REQ-027 start while busy SHALL be ignored; captured limits SHALL not change mid-run.
REQ-028 count SHALL never exceed hi nor go below lo during a run; no wrap-around for any W-bit limits, including lo=0, hi=2^W-1.
REQ-029 hi-lo=1 SHALL alternate lo,hi,lo,... with period 2.
REQ-030 Sweep counter SHALL be SW bits; sweeps=0 continuous mode SHALL let it wrap freely without terminating.

Reset
REQ-031 rst=0 at a clk edge SHALL set state IDLE, count=0, up_down=1, busy=0, done=0, err=0, sweep counter=0, captured limits=0.
REQ-032 Reset SHALL override start/abort and take effect from any state, including mid-sweep.

Structure
REQ-033 State encodings and default W/SW SHALL live in shared include updown_pkg.vh for reuse by counter blocks and benches.
REQ-034 Counter datapath (load, enable, direction) SHALL be a sub-module updown_sweep_cnt; FSM and limit/sweep registers SHALL reside in updown_sweep_ctrl.

Verification
REQ-035 rst low 2 cycles -> count=0, up_down=1, busy=0, done=0, err=0.
REQ-036 lo=2, hi=5, sweeps=1, start pulse -> count 2,3,4,5,4,3,2,2; done high on final 2; then busy=0.
REQ-037 lo=2, hi=5, sweeps=0 -> period 6 repeating 2..5..3; abort mid-DOWN at count=4 -> IDLE next cycle, count holds 4, no done.
REQ-038 lo=7, hi=7, start -> err one cycle, busy stays 0, count unchanged; lo=9, hi=3 -> same.
REQ-039 lo=0, hi=255, sweeps=2 -> no wrap, 510 cycles per sweep, done after second return to 0.
REQ-040 start+abort same cycle in IDLE -> no run, no err; start during run with new limits -> ignored, sweep continues on original limits.

Source files
------------

// File: rtl/updown_pkg.sv
// Shared definitions for the up/down sweep controller, its counter and benches.
// Holds the FSM state encoding and the default datapath widths.
package updown_pkg;

  localparam int DEF_W  = 8;
  localparam int DEF_SW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/updown_sweep_cnt.sv
// Loadable up/down counter; load has priority over enable.
// Holds its value whenever neither load nor enable is asserted.
module updown_sweep_cnt
  import updown_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] count
);

  // NOTE: reset is synchronous and active-low, so it sits inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? count + W'(1) : count - W'(1);
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep controller: runs a counter lo..hi..lo for a set number of sweeps or until abort.
// FSM, captured limits and sweep counter live here; the counter datapath is a sub-module.
module updown_sweep_ctrl
  import updown_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int SW = DEF_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  input  logic [SW-1:0] sweeps,
  output logic [W-1:0]  count,
  output logic          up_down,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        state, nxt;
  logic [W-1:0]  lo_q, hi_q;
  logic [SW-1:0] sw_q, sweep_cnt, sweep_nxt;
  logic          cnt_load, cnt_en, cnt_up, capture, reject, bump;
  logic [W-1:0]  cnt_val;

  assign sweep_nxt = sweep_cnt + SW'(1);

  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    nxt      = state;
    cnt_load = 1'b0;
    cnt_val  = lo_q;
    cnt_en   = 1'b0;
    cnt_up   = 1'b1;
    capture  = 1'b0;
    reject   = 1'b0;
    bump     = 1'b0;
    case (state)
      ST_IDLE: begin
        // abort outranks start even in IDLE: nothing is captured and no err is raised
        if (start && !abort) begin
          if (lo < hi) begin
            capture  = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = lo;
            nxt      = ST_UP;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_UP: begin
        if (abort) begin
          nxt = ST_IDLE;
        end else if (count == hi_q) begin
          cnt_load = 1'b1;
          cnt_val  = hi_q - W'(1);
          nxt      = ST_DOWN;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DOWN: begin
        if (abort) begin
          nxt = ST_IDLE;
        end else if (count == lo_q) begin
          bump = 1'b1;
          if (sw_q != '0 && sweep_nxt == sw_q) begin
            nxt = ST_DONE;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = lo_q + W'(1);
            nxt      = ST_UP;
          end
        end else begin
          cnt_en = 1'b1;
          cnt_up = 1'b0;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      sw_q      <= '0;
      sweep_cnt <= '0;
      up_down   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= nxt;
      if (capture) begin
        lo_q      <= lo;
        hi_q      <= hi;
        sw_q      <= sweeps;
        sweep_cnt <= '0;
      end else if (bump) begin
        sweep_cnt <= sweep_nxt;
      end
      // flags are decoded from the next state so they line up with the state they describe
      up_down <= (nxt != ST_DOWN);
      busy    <= (nxt != ST_IDLE);
      done    <= (nxt == ST_DONE);
      err     <= reject;
    end
  end

  updown_sweep_cnt #(.W(W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .up       (cnt_up),
    .count    (count)
  );

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl: vector table plus multi-cycle sweep sequences.
module tb_updown_sweep_ctrl;
  import updown_pkg::*;

  localparam int W  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [W-1:0]  lo, hi;
  logic [SW-1:0] sweeps;
  logic [W-1:0]  count;
  logic          up_down, busy, done, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  updown_sweep_ctrl #(.W(W), .SW(SW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .lo      (lo),
    .hi      (hi),
    .sweeps  (sweeps),
    .count   (count),
    .up_down (up_down),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  typedef struct {
    logic          start;
    logic          abort;
    logic [W-1:0]  lo;
    logic [W-1:0]  hi;
    logic [SW-1:0] sweeps;
    logic [W-1:0]  e_count;
    logic          e_up;
    logic          e_busy;
    logic          e_done;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic a, input logic [W-1:0] l,
                              input logic [W-1:0] h, input logic [SW-1:0] sw,
                              input logic [W-1:0] c, input logic u, input logic b,
                              input logic d, input logic e);
    vec_t v;
    v.start = s; v.abort = a; v.lo = l; v.hi = h; v.sweeps = sw;
    v.e_count = c; v.e_up = u; v.e_busy = b; v.e_done = d; v.e_err = e;
    return v;
  endfunction

  // packed view {err, done, busy, up_down, count}
  function automatic logic [31:0] pk(input logic [W-1:0] c, input logic u, input logic b,
                                     input logic d, input logic e);
    return {20'd0, e, d, b, u, c};
  endfunction

  function automatic logic [W-1:0] m_count(input int l, input int h, input int k);
    int d, p;
    d = h - l;
    if (k == 0) return W'(l);
    p = (k - 1) % (2 * d);
    if (p < d) return W'(l + 1 + p);
    return W'(h - 1 - (p - d));
  endfunction

  function automatic logic m_up(input int l, input int h, input int k);
    int d;
    d = h - l;
    if (k == 0) return 1'b1;
    return ((k - 1) % (2 * d)) < d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {err,done,busy,up,count}=%h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return pk(count, up_down, busy, done, err);
  endfunction

  // start a run and follow it cycle by cycle; n=0 follows `cycles` cycles of continuous mode
  task automatic run_sweep(input int l, input int h, input int n, input int cycles);
    int last;
    lo = W'(l); hi = W'(h); sweeps = SW'(n); start = 1'b1;
    step();
    start = 1'b0;
    last = (n == 0) ? cycles : 2 * (h - l) * n;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) step();
      check($sformatf("run %0d..%0d k=%0d", l, h, k), dut_vec(),
            pk(m_count(l, h, k), m_up(l, h, k), 1'b1, 1'b0, 1'b0));
    end
    if (n != 0) begin
      step();
      check($sformatf("done %0d..%0d", l, h), dut_vec(), pk(W'(l), 1'b1, 1'b1, 1'b1, 1'b0));
      step();
      check($sformatf("idle %0d..%0d", l, h), dut_vec(), pk(W'(l), 1'b1, 1'b0, 1'b0, 1'b0));
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; lo = '0; hi = '0; sweeps = '0;
    step();
    step();
    check("reset", dut_vec(), pk(8'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;

    // single sweep 2..5, with a mid-run start carrying new limits
    vecs.push_back(mk(1, 0, 8'd2, 8'd5, 4'd1, 8'd2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd2, 8'd5, 4'd1, 8'd3, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'd0, 8'd9, 4'd0, 8'd4, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 8'd9, 4'd0, 8'd5, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 8'd9, 4'd0, 8'd4, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 8'd9, 4'd0, 8'd3, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 8'd9, 4'd0, 8'd2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 8'd9, 4'd0, 8'd2, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'd0, 8'd9, 4'd0, 8'd2, 1, 0, 0, 0));
    // rejected starts: lo == hi, then lo > hi
    vecs.push_back(mk(1, 0, 8'd7, 8'd7, 4'd1, 8'd2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'd7, 8'd7, 4'd1, 8'd2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'd9, 8'd3, 4'd1, 8'd2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'd9, 8'd3, 4'd1, 8'd2, 1, 0, 0, 0));
    // start and abort together in IDLE
    vecs.push_back(mk(1, 1, 8'd1, 8'd4, 4'd1, 8'd2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd1, 8'd4, 4'd1, 8'd2, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      start = vecs[i].start; abort = vecs[i].abort;
      lo = vecs[i].lo; hi = vecs[i].hi; sweeps = vecs[i].sweeps;
      step();
      check($sformatf("vec %0d", i), dut_vec(),
            pk(vecs[i].e_count, vecs[i].e_up, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err));
    end
    start = 1'b0; abort = 1'b0;

    // continuous mode for 20+ periods (sweep counter wraps), ending at count=4 going down
    run_sweep(2, 5, 0, 124);
    abort = 1'b1;
    step();
    check("abort", dut_vec(), pk(8'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    abort = 1'b0;
    step();
    check("after abort", dut_vec(), pk(8'd4, 1'b1, 1'b0, 1'b0, 1'b0));

    run_sweep(10, 11, 3, 0);
    run_sweep(0, 255, 2, 0);

    // reset mid-sweep overrides a concurrent start
    run_sweep(2, 5, 0, 4);
    rst = 1'b0; start = 1'b1; lo = 8'd1; hi = 8'd6;
    step();
    check("reset mid-sweep", dut_vec(), pk(8'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    rst = 1'b1; start = 1'b0;
    step();
    check("idle after reset", dut_vec(), pk(8'd0, 1'b1, 1'b0, 1'b0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
